bitwise_logic_pipe: RTL and testbench



---
 rtl/bitwise_logic_pipe_if.sv | 32 +++
 rtl/bitwise_logic_pipe.sv | 128 ++++++++++++
 tb/tb_bitwise_logic_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bitwise_logic_pipe_if.sv
// bitwise_logic_pipe_if
// Handshake bundle for bitwise_logic_pipe.
//   Input side : in_valid, in_ready, A, B, op
//   Output side: out_valid, out_ready, result, zero, negative
// The master modport is the producer/consumer environment around the pipe.
// The slave modport is the pipe itself.
`timescale 1ns/1ps

interface bitwise_logic_pipe_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             negative;

    modport master (
        output in_valid, A, B, op, out_ready,
        input  in_ready, out_valid, result, zero, negative
    );

    modport slave (
        input  in_valid, A, B, op, out_ready,
        output in_ready, out_valid, result, zero, negative
    );
endinterface

// File: rtl/bitwise_logic_pipe.sv
// bitwise_logic_pipe
// Pipelined bitwise unit. It applies one of eight bitwise operations to A and B.
// The result then passes through STAGES registered stages, which use a
// valid/ready handshake and give full backpressure.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   bus       bitwise_logic_pipe_if.slave:
//             in_valid/in_ready/A/B/op in, out_valid/out_ready/result/zero/negative out
//   op_count  count of output transfers, wraps at 2^CNT_W
//
// Optional feature macro: BITWISE_LOGIC_FLAGS_EN
//   When it is defined, the zero and negative flags are computed at stage 0.
//   They then travel with the result through every stage.
//   When it is undefined, both flag outputs are tied to 0.
`timescale 1ns/1ps

module bitwise_logic_pipe #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    bitwise_logic_pipe_if.slave bus,
    output logic [CNT_W-1:0]  op_count
);

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] adv;
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [WIDTH-1:0]  res_d;

    always_comb begin
        res_d = '0;
        unique case (bus.op)
            3'b000: res_d = bus.A & bus.B;
            3'b001: res_d = bus.A | bus.B;
            3'b010: res_d = bus.A ^ bus.B;
            3'b011: res_d = ~(bus.A | bus.B);
            3'b100: res_d = bus.A & ~bus.B;
            3'b101: res_d = bus.A | ~bus.B;
            3'b110: res_d = bus.A;
            3'b111: res_d = ~bus.A;
            default: res_d = '0;
        endcase
    end

    // adv[i]: stage i may load this cycle.
    // A stage may load if it is empty now, or if its contents move on to the
    // next stage (or out of the pipe) in this same cycle.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = !vld[STAGES-1] || bus.out_ready;
        for (int i = STAGES - 2; i >= 0; i--) begin
            adv[i] = !vld[i] || adv[i+1];
        end
    end

    assign bus.in_ready  = adv[0];
    assign bus.out_valid = vld[STAGES-1];
    assign bus.result    = res_q[STAGES-1];

    // Data registers load only when a valid entry arrives.
    // As a result, a bubble leaves the previous value in place.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
            for (int i = 0; i < STAGES; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            if (adv[0]) begin
                vld[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    res_q[0] <= res_d;
                end
            end
            for (int i = 1; i < STAGES; i++) begin
                if (adv[i]) begin
                    vld[i] <= vld[i-1];
                    if (vld[i-1]) begin
                        res_q[i] <= res_q[i-1];
                    end
                end
            end
        end
    end

`ifdef BITWISE_LOGIC_FLAGS_EN
    logic [STAGES-1:0] zero_q;
    logic [STAGES-1:0] neg_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            zero_q <= '0;
            neg_q  <= '0;
        end else begin
            if (adv[0] && bus.in_valid) begin
                zero_q[0] <= (res_d == '0);
                neg_q[0]  <= res_d[WIDTH-1];
            end
            for (int i = 1; i < STAGES; i++) begin
                if (adv[i] && vld[i-1]) begin
                    zero_q[i] <= zero_q[i-1];
                    neg_q[i]  <= neg_q[i-1];
                end
            end
        end
    end

    assign bus.zero     = zero_q[STAGES-1];
    assign bus.negative = neg_q[STAGES-1];
`else
    assign bus.zero     = 1'b0;
    assign bus.negative = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            op_count <= '0;
        end else if (bus.out_valid && bus.out_ready) begin
            op_count <= op_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
`timescale 1ns/1ps

module tb_bitwise_logic_pipe;
    localparam int W  = 64;
    localparam int ST = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] op_count;
    logic [3:0]  op_count_w;

    bitwise_logic_pipe_if #(.WIDTH(W)) bus ();
    bitwise_logic_pipe_if #(.WIDTH(W)) bus_w ();

    bitwise_logic_pipe #(.WIDTH(W), .STAGES(ST), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .bus(bus), .op_count(op_count)
    );

    // Second instance with a 4-bit counter, fed the same stimulus, for wrap checks.
    bitwise_logic_pipe #(.WIDTH(W), .STAGES(ST), .CNT_W(4)) dut_w (
        .clk(clk), .reset(reset), .bus(bus_w), .op_count(op_count_w)
    );

    assign bus_w.in_valid  = bus.in_valid;
    assign bus_w.A         = bus.A;
    assign bus_w.B         = bus.B;
    assign bus_w.op        = bus.op;
    assign bus_w.out_ready = bus.out_ready;

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: the op table applied to whole operands.
    function automatic logic [W-1:0] model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [2:0] o);
        case (o)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~(a | b);
            3'd4: return a & ~b;
            3'd5: return a | ~b;
            3'd6: return a;
            default: return ~a;
        endcase
    endfunction

    typedef struct {
        logic [W-1:0] r;
        logic         z;
        logic         n;
        int           cyc;
    } exp_t;

    exp_t         mq[$];
    exp_t         e_pop;
    exp_t         e_push;
    logic [W-1:0] rlog[$];
    logic         zlog[$];
    logic         nlog[$];
    int           cyc = 0;
    int           mcnt = 0;
    bit           lat_chk = 0;
    bit           prev_stall = 0;
    logic [W-1:0] prev_res;

    // Compare process: model of pipe contents as a FIFO of expected results.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            mq.delete();
            mcnt = 0;
            prev_stall = 0;
        end else begin
            chk("op_count", 64'(op_count), 64'(mcnt));
            chk("op_count_w", 64'(op_count_w), 64'(mcnt % 16));
            chk("in_ready", 64'(bus.in_ready), 64'((mq.size() < ST) || bus.out_ready));
            if (bus.out_valid !== 1'b0 && mq.size() == 0)
                chk("stale_out_valid", 64'(bus.out_valid), 64'(0));
            if (prev_stall) begin
                chk("hold_valid", 64'(bus.out_valid), 64'(1));
                chk("hold_result", 64'(bus.result), 64'(prev_res));
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_res   = bus.result;
            if (bus.out_valid && bus.out_ready && mq.size() > 0) begin
                e_pop = mq.pop_front();
                chk("result", 64'(bus.result), 64'(e_pop.r));
                chk("zero", 64'(bus.zero), 64'(e_pop.z));
                chk("negative", 64'(bus.negative), 64'(e_pop.n));
                if (lat_chk) chk("latency", 64'(cyc - e_pop.cyc), 64'(ST));
                rlog.push_back(bus.result);
                zlog.push_back(bus.zero);
                nlog.push_back(bus.negative);
                mcnt++;
            end
            if (bus.in_valid && bus.in_ready) begin
                e_push.r   = model_op(bus.A, bus.B, bus.op);
`ifdef BITWISE_LOGIC_FLAGS_EN
                e_push.z   = (e_push.r == '0);
                e_push.n   = e_push.r[W-1];
`else
                e_push.z   = 1'b0;
                e_push.n   = 1'b0;
`endif
                e_push.cyc = cyc;
                mq.push_back(e_push);
            end
        end
    end

    logic [W-1:0] va[$];
    logic [W-1:0] vb[$];
    logic [2:0]   vo[$];
    int           vidx = 0;
    int           ir_low = 0;

    task automatic clear_vec();
        va.delete(); vb.delete(); vo.delete();
        vidx = 0;
    endtask

    task automatic add_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] o);
        va.push_back(a); vb.push_back(b); vo.push_back(o);
    endtask

    // Called at posedge+1. Each cycle presents the next pending vector.
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            if (vidx < va.size()) begin
                bus.in_valid = 1'b1;
                bus.A  = va[vidx];
                bus.B  = vb[vidx];
                bus.op = vo[vidx];
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            if (bus.in_valid && !bus.in_ready) ir_low++;
            if (bus.in_valid && bus.in_ready) vidx++;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic run_all(input int budget, output int used);
        used = 0;
        while (vidx < va.size() && used < budget) begin
            run_cycles(1);
            used++;
        end
        chk("run_timeout", 64'(vidx), 64'(va.size()));
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while (mq.size() != 0 && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("drain_timeout", 64'(mq.size()), 64'(0));
    endtask

    logic [W-1:0] sweep_a = 64'h1010101010101010;
    logic [W-1:0] sweep_b = 64'h0101010101010101;
    logic [W-1:0] sweep_exp [8] = '{64'h0, 64'h1111111111111111, 64'h1111111111111111,
                                    64'hEEEEEEEEEEEEEEEE, 64'h1010101010101010,
                                    64'hFEFEFEFEFEFEFEFE, 64'h1010101010101010,
                                    64'hEFEFEFEFEFEFEFEF};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int used;
        int v0;
        int seen;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.op        = 3'd0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
        chk("rst_result", 64'(bus.result), 64'(0));
        chk("rst_zero", 64'(bus.zero), 64'(0));
        chk("rst_negative", 64'(bus.negative), 64'(0));
        chk("rst_op_count", 64'(op_count), 64'(0));
        @(posedge clk);
        #1;

        // Op sweep
        for (int i = 0; i < 8; i++)
            chk("model_pin", 64'(model_op(sweep_a, sweep_b, 3'(i))), 64'(sweep_exp[i]));
        clear_vec();
        for (int i = 0; i < 8; i++) add_vec(sweep_a, sweep_b, 3'(i));
        rlog.delete();
        lat_chk = 1;
        run_all(20, used);
        chk("sweep_throughput", 64'(used), 64'(8));
        drain(10);
        lat_chk = 0;
        chk("sweep_count", 64'(rlog.size()), 64'(8));
        for (int i = 0; i < 8 && i < rlog.size(); i++)
            chk("sweep_result", 64'(rlog[i]), 64'(sweep_exp[i]));
        chk("sweep_op_count", 64'(op_count), 64'(8));

        // Backpressure
        clear_vec();
        for (int i = 1; i <= 4; i++) add_vec(W'(i), '0, 3'd1);
        rlog.delete();
        bus.out_ready = 1'b0;
        run_cycles(5);
        chk("bp_accepted", 64'(vidx), 64'(2));
        chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
        chk("bp_out_valid", 64'(bus.out_valid), 64'(1));
        chk("bp_result", 64'(bus.result), 64'(1));
        bus.out_ready = 1'b1;
        run_all(20, used);
        drain(10);
        chk("bp_count", 64'(rlog.size()), 64'(4));
        for (int i = 0; i < 4 && i < rlog.size(); i++)
            chk("bp_order", 64'(rlog[i]), 64'(i + 1));

        // Full pass-through
        clear_vec();
        for (int i = 0; i < 12; i++)
            add_vec(W'(64'h0123456789ABCDEF * (i + 1)), W'(64'hF0F0_0F0F_3C3C_A5A5 >> i), 3'(i % 8));
        bus.out_ready = 1'b0;
        run_cycles(3);
        chk("pt_fill", 64'(vidx), 64'(2));
        bus.out_ready = 1'b1;
        ir_low = 0;
        v0 = vidx;
        run_cycles(10);
        chk("pt_accepted", 64'(vidx - v0), 64'(10));
        chk("pt_in_ready_low", 64'(ir_low), 64'(0));
        chk("pt_op_count", 64'(op_count), 64'(22));
        drain(10);

        // Reset mid-flight
        clear_vec();
        add_vec(64'hAAAA, 64'h5555, 3'd1);
        add_vec(64'h1234, 64'h00FF, 3'd2);
        bus.out_ready = 1'b0;
        run_cycles(2);
        chk("rf_accepted", 64'(vidx), 64'(2));
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("rf_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rf_op_count", 64'(op_count), 64'(0));
        chk("rf_result", 64'(bus.result), 64'(0));
        chk("rf_in_ready", 64'(bus.in_ready), 64'(1));
        bus.out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen++;
        end
        chk("rf_stale", 64'(seen), 64'(0));
        @(posedge clk);
        #1;

        // Flags
        clear_vec();
        add_vec(64'hFFFFFFFFFFFFFFFF, 64'h0, 3'd0);
        add_vec(64'hFFFFFFFFFFFFFFFF, 64'h0, 3'd6);
        zlog.delete(); nlog.delete(); rlog.delete();
        lat_chk = 1;
        run_all(10, used);
        drain(10);
        lat_chk = 0;
        chk("flag_count", 64'(zlog.size()), 64'(2));
        if (zlog.size() == 2) begin
`ifdef BITWISE_LOGIC_FLAGS_EN
            chk("flag_and_zero", 64'(zlog[0]), 64'(1));
            chk("flag_and_neg", 64'(nlog[0]), 64'(0));
            chk("flag_pass_zero", 64'(zlog[1]), 64'(0));
            chk("flag_pass_neg", 64'(nlog[1]), 64'(1));
`else
            chk("flag_and_zero", 64'(zlog[0]), 64'(0));
            chk("flag_and_neg", 64'(nlog[0]), 64'(0));
            chk("flag_pass_zero", 64'(zlog[1]), 64'(0));
            chk("flag_pass_neg", 64'(nlog[1]), 64'(0));
`endif
        end

        // Counter wrap
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        clear_vec();
        for (int i = 0; i < 17; i++) add_vec(W'(i), W'(~i), 3'(i % 8));
        run_all(40, used);
        drain(10);
        chk("wrap_op_count_w", 64'(op_count_w), 64'(1));
        chk("wrap_op_count", 64'(op_count), 64'(17));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
